sram_arb_2x32: RTL
==================

// Module: sram_arb_2x32
// PURPOSE
//  Two-master arbiter that shares one 32-bit SRAM bus port (9-bit word address, 4 byte enables, ce/wait) between two 32-bit requesters.
//  Typical use: instruction fetch on m0 and load/store on m1.
//  The arbiter sits between the two masters and the 32->16 SRAM width converter.
//  It muxes the owning master onto the slave port and holds the losing master in wait.
// PARAMETERS
//  ADDR_W     9   word address width, shared by master and slave ports
//  DATA_W     32  data width; byte-enable width BE_W = DATA_W/8
//  MAX_BURST  4   max consecutive completions by the owner while the other master requests (1..15)
// PORTS
//  clock      in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active low
//  m0_address in   ADDR_W  master 0 word address; same set for m1_*
//  m0_byteena in   BE_W    master 0 byte enables
//  m0_data    in   DATA_W  master 0 write data
//  m0_wren    in   1       master 0 write (1) / read (0)
//  m0_ce      in   1       master 0 request; held with stable fields until completion
//  m0_q       out  DATA_W  master 0 read data, valid in its completion cycle
//  m0_wait    out  1       master 0 stall; completion = m0_ce & ~m0_wait
//  s_address  out  ADDR_W  slave port (to converter)
//  s_byteena  out  BE_W    slave port
//  s_data     out  DATA_W  slave port
//  s_wren     out  1       slave port
//  s_ce       out  1       slave port
//  s_q        in   DATA_W  slave read data
//  s_wait     in   1       slave stall
// BEHAVIOUR
//  FSM (one-hot): IDLE, OWN0, OWN1. Regs: last_owner (1b), burst_cnt (4b, saturating).
//  Reset (async, rst_n=0), effective immediately:
//   - state=IDLE, last_owner=1 (m0 wins first), burst_cnt=0.
//   - Outputs: s_ce=0, s_wren=0, s_address/s_byteena/s_data=0, m0_wait=m1_wait=1, m0_q=m1_q=0.
//  IDLE:
//   - Slave fields all 0; both m*_wait=1.
//   - If any ce: next=OWNx. When both request, x = the master that is not last_owner.
//   - Arbitration latency is 1 cycle: request seen in cycle N, slave ce asserted in N+1.
//  OWNx, combinational paths:
//   - s_* = mx_* fields; s_ce = mx_ce.
//   - mx_wait = s_wait; mx_q = s_q.
//   - Other master: wait=1, q=0.
//  Completion = s_ce & ~s_wait. On completion burst_cnt++ (saturating); last_owner <= x.
//  OWNx transitions, in priority order:
//   - Completion & other ce & (burst_cnt+1 >= MAX_BURST): next=OWN(other), burst_cnt=0. Handover has no idle cycle.
//   - Completion, otherwise: stay OWNx.
//   - mx_ce=0 (owner released, no transfer): if other ce, next=OWN(other) with burst_cnt=0; else IDLE with burst_cnt=0.
//   - s_wait=1: stay OWNx. Grant never changes while a transfer is stalled, even if the other master requests.
//  If the other master is not requesting, the owner keeps the grant indefinitely; burst_cnt saturates at 15.
//  Simultaneous requests on a handover cycle: the handover decision above wins; last_owner updates as normal.
//  The slave wait path (s_wait->mx_wait) and read path (s_q->mx_q) are purely combinational; no added read latency.
//  Reset mid-transfer aborts it: s_ce drops asynchronously and the masters must re-request after reset.
// TESTING
//  1. Single read: m0 ce, addr 9'h012, s_wait=0, s_q=32'hDEADBEEF -> cycle+1: s_ce=1, s_address=9'h012, m0_wait=0, m0_q=32'hDEADBEEF; m1_wait=1 throughout.
//  2. Both ce at once after reset, MAX_BURST=1 -> m0 completes first, then m1 gets s_ce on the very next cycle; grants alternate m0,m1,m0,...
//  3. MAX_BURST=4; m0 and m1 both hold ce, m0 owns, s_wait=0 -> exactly 4 m0 completions, then an m1 completion; no idle gap between them.
//  4. m0 owns, m1 requests, s_wait=1 for 3 cycles -> m0_wait=1 for those 3 cycles, grant stays m0, then m0 completes; s_address never shows m1's address during the stall.
//  5. m0 owns and drops ce with no completion, m1 idle -> next state IDLE; s_ce=0, both waits=1.
//  6. rst_n pulsed low mid-stalled write (s_wren=1) -> s_ce=0, s_wren=0, m0_wait=m1_wait=1 in the same cycle; after release, m0 wins the first arbitration.

Source files
------------

// File: rtl/sram_arb_2x32.sv
// ============================================================================
// sram_arb_2x32 : two-master arbiter sharing one SRAM port, burst-limited fairness
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_arb_2x32 #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteena,
    input  logic [DATA_W-1:0]     m0_data,
    input  logic                  m0_wren,
    input  logic                  m0_ce,
    output logic [DATA_W-1:0]     m0_q,
    output logic                  m0_wait,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteena,
    input  logic [DATA_W-1:0]     m1_data,
    input  logic                  m1_wren,
    input  logic                  m1_ce,
    output logic [DATA_W-1:0]     m1_q,
    output logic                  m1_wait,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteena,
    output logic [DATA_W-1:0]     s_data,
    output logic                  s_wren,
    output logic                  s_ce,
    input  logic [DATA_W-1:0]     s_q,
    input  logic                  s_wait
);

    localparam logic [4:0] c_MAX_BURST = 5'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_OWN0 = 3'b010,
        S_OWN1 = 3'b100
    } state_t;

    state_t     r_state;
    logic       r_last_owner;
    logic [3:0] r_burst_cnt;

    logic       w_own0;
    logic       w_own1;
    logic       w_owner_ce;
    logic       w_other_ce;
    logic       w_comp;
    logic [4:0] w_cnt_inc;
    logic [3:0] w_cnt_sat;
    logic       w_burst_done;
    state_t     w_other_state;

    assign w_own0        = (r_state == S_OWN0);
    assign w_own1        = (r_state == S_OWN1);
    assign w_owner_ce    = w_own0 ? m0_ce : m1_ce;
    assign w_other_ce    = w_own0 ? m1_ce : m0_ce;
    assign w_comp        = (w_own0 | w_own1) & w_owner_ce & ~s_wait;
    assign w_cnt_inc     = {1'b0, r_burst_cnt} + 5'd1;
    assign w_cnt_sat     = (r_burst_cnt == 4'hF) ? 4'hF : w_cnt_inc[3:0];
    assign w_burst_done  = (w_cnt_inc >= c_MAX_BURST);
    assign w_other_state = w_own0 ? S_OWN1 : S_OWN0;

    // Slave port and wait/read paths are steered by the registered grant only.
    always_comb begin
        s_address = '0;
        s_byteena = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        s_ce      = 1'b0;
        m0_wait   = 1'b1;
        m1_wait   = 1'b1;
        m0_q      = '0;
        m1_q      = '0;
        if (w_own0) begin
            s_address = m0_address;
            s_byteena = m0_byteena;
            s_data    = m0_data;
            s_wren    = m0_wren;
            s_ce      = m0_ce;
            m0_wait   = s_wait;
            m0_q      = s_q;
        end else if (w_own1) begin
            s_address = m1_address;
            s_byteena = m1_byteena;
            s_data    = m1_data;
            s_wren    = m1_wren;
            s_ce      = m1_ce;
            m1_wait   = s_wait;
            m1_q      = s_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_ce && m1_ce)
                        r_state <= r_last_owner ? S_OWN0 : S_OWN1;
                    else if (m0_ce)
                        r_state <= S_OWN0;
                    else if (m1_ce)
                        r_state <= S_OWN1;
                end
                S_OWN0, S_OWN1: begin
                    if (w_comp) begin
                        r_last_owner <= w_own1;
                        if (w_other_ce && w_burst_done) begin
                            r_state     <= w_other_state;
                            r_burst_cnt <= 4'd0;
                        end else begin
                            r_burst_cnt <= w_cnt_sat;
                        end
                    end else if (!w_owner_ce) begin
                        // Owner withdrew without a transfer: release immediately.
                        r_burst_cnt <= 4'd0;
                        r_state     <= w_other_ce ? w_other_state : S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_burst_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
